// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for a single-issue fetch stage.
// Chooses the next PC from sequential, jump, jump-register and branch
// sources. A redirect that arrives while the fetch is still outstanding
// is parked in pend_pc until the instruction memory answers.
//
// state | meaning
// ------+-------------------------------------------------------------
// FETCH | normal fetch; PC advances on every accepted word
// PEND  | redirect target latched in pend_pc, waiting for ihit
// HALT  | HALT retired; fetch off, PC and icount frozen until RST
module pc_sequencer #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  pcsrc,
  input  logic        zero_sel,
  input  logic        zero,
  input  logic [25:0] jaddr,
  input  logic [15:0] imm16,
  input  logic [31:0] rdat1,
  input  logic        ihit,
  input  logic        stall,
  input  logic        halt,
  output logic [31:0] imemaddr,
  output logic        imemREN,
  output logic [31:0] pc_plus4,
  output logic        redirect,
  output logic        halted,
  output logic [31:0] icount
);

  localparam logic [1:0] SRC_ADD4   = 2'd0;
  localparam logic [1:0] SRC_JUMP   = 2'd1;
  localparam logic [1:0] SRC_JR     = 2'd2;
  localparam logic [1:0] SRC_BRANCH = 2'd3;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_PEND  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic [31:0] br_offset;
  logic [31:0] target;
  logic        taken;
  logic        is_redir;
  logic        advance;
  logic        halt_now;

  // Control strobes produced by the next-state logic for the datapath.
  logic        pc_load;
  logic        pc_from_pend;
  logic        pend_load;
  logic        redir_set;

  assign pc_plus4  = pc + 32'd4;
  assign imemaddr  = pc;
  assign br_offset = {{14{imm16[15]}}, imm16, 2'b00};
  assign taken     = (pcsrc == SRC_BRANCH) && (zero == zero_sel);
  assign is_redir  = (pcsrc == SRC_JUMP) || (pcsrc == SRC_JR) || taken;
  assign advance   = ihit && !stall && (state != ST_HALT);
  // A HALT word that is actually accepted this cycle; it beats any redirect.
  assign halt_now  = halt && advance;

  // Next-PC target mux; all arithmetic wraps modulo 2^32.
  always_comb begin
    target = pc_plus4;
    case (pcsrc)
      SRC_ADD4:   target = pc_plus4;
      SRC_JUMP:   target = {pc_plus4[31:28], jaddr, 2'b00};
      SRC_JR:     target = rdat1;
      SRC_BRANCH: target = taken ? (pc_plus4 + br_offset) : pc_plus4;
      default:    target = pc_plus4;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_next   = state;
    pc_load      = 1'b0;
    pc_from_pend = 1'b0;
    pend_load    = 1'b0;
    redir_set    = 1'b0;
    case (state)
      ST_FETCH: begin
        if (halt_now) begin
          state_next = ST_HALT;
        end else if (advance) begin
          pc_load   = 1'b1;
          redir_set = is_redir;
        end else if (is_redir && !ihit && !stall) begin
          pend_load  = 1'b1;
          state_next = ST_PEND;
        end
      end
      ST_PEND: begin
        if (halt_now) begin
          state_next = ST_HALT;
        end else if (advance) begin
          // The parked target wins; whatever pcsrc shows now is ignored.
          pc_load      = 1'b1;
          pc_from_pend = 1'b1;
          redir_set    = 1'b1;
          state_next   = ST_FETCH;
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    imemREN = 1'b0;
    halted  = 1'b0;
    case (state)
      ST_FETCH: imemREN = 1'b1;
      ST_PEND:  imemREN = 1'b1;
      ST_HALT:  halted  = 1'b1;
      default:  imemREN = 1'b0;
    endcase
  end

  // PC, parked target and retired-fetch counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc      <= PC_INIT;
      pend_pc <= 32'h0000_0000;
      icount  <= 32'h0000_0000;
    end else begin
      if (pc_load) begin
        pc     <= pc_from_pend ? pend_pc : target;
        icount <= icount + 32'd1;
      end
      if (pend_load) begin
        pend_pc <= target;
      end
    end
  end

  // Redirect pulse: high only in the cycle after a non-sequential load.
  always_ff @(posedge CLK) begin
    if (RST) begin
      redirect <= 1'b0;
    end else begin
      redirect <= redir_set;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed tests for pc_sequencer with hand-computed values.
module tb_pc_sequencer;

  logic        CLK;
  logic        RST;
  logic [1:0]  pcsrc;
  logic        zero_sel;
  logic        zero;
  logic [25:0] jaddr;
  logic [15:0] imm16;
  logic [31:0] rdat1;
  logic        ihit;
  logic        stall;
  logic        halt;
  logic [31:0] imemaddr;
  logic        imemREN;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        halted;
  logic [31:0] icount;

  int vectors;
  int miscompares;

  pc_sequencer #(.PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .pcsrc(pcsrc), .zero_sel(zero_sel), .zero(zero),
    .jaddr(jaddr), .imm16(imm16), .rdat1(rdat1), .ihit(ihit), .stall(stall),
    .halt(halt), .imemaddr(imemaddr), .imemREN(imemREN), .pc_plus4(pc_plus4),
    .redirect(redirect), .halted(halted), .icount(icount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    pcsrc = 2'd0; zero_sel = 1'b0; zero = 1'b0; jaddr = '0; imm16 = '0;
    rdat1 = '0; ihit = 1'b0; stall = 1'b0; halt = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (imemaddr !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h want %h", imemaddr, 32'h0); end
    vectors++; if (icount !== 32'h0) begin miscompares++; $display("FAIL reset_icount got %h want %h", icount, 32'h0); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted got %b want 0", halted); end
    vectors++; if (imemREN !== 1'b1) begin miscompares++; $display("FAIL reset_imemREN got %b want 1", imemREN); end
    vectors++; if (redirect !== 1'b0) begin miscompares++; $display("FAIL reset_redirect got %b want 0", redirect); end
    vectors++; if (pc_plus4 !== 32'h4) begin miscompares++; $display("FAIL reset_pc_plus4 got %h want %h", pc_plus4, 32'h4); end
  endtask

  task automatic test_add4();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
    do_reset();
    pcsrc = 2'd0; ihit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (imemaddr !== exp_pc[i]) begin miscompares++; $display("FAIL add4_pc[%0d] got %h want %h", i, imemaddr, exp_pc[i]); end
      vectors++; if (redirect !== 1'b0) begin miscompares++; $display("FAIL add4_redirect[%0d] got %b want 0", i, redirect); end
    end
    ihit = 1'b0;
    vectors++; if (icount !== 32'd3) begin miscompares++; $display("FAIL add4_icount got %0d want 3", icount); end
    vectors++; if (pc_plus4 !== 32'h10) begin miscompares++; $display("FAIL add4_pc_plus4 got %h want %h", pc_plus4, 32'h10); end
  endtask

  task automatic test_branch();
    do_reset();
    pcsrc = 2'd2; rdat1 = 32'h100; ihit = 1'b1;
    tick();
    vectors++; if (imemaddr !== 32'h100) begin miscompares++; $display("FAIL br_setup_pc got %h want %h", imemaddr, 32'h100); end
    // BEQ taken, offset -1 word: 0x104 - 4 = 0x100
    pcsrc = 2'd3; zero_sel = 1'b1; zero = 1'b1; imm16 = 16'hFFFF;
    tick();
    vectors++; if (imemaddr !== 32'h100) begin miscompares++; $display("FAIL beq_taken_pc got %h want %h", imemaddr, 32'h100); end
    vectors++; if (redirect !== 1'b1) begin miscompares++; $display("FAIL beq_taken_redirect got %b want 1", redirect); end
    zero = 1'b0;
    tick();
    vectors++; if (imemaddr !== 32'h104) begin miscompares++; $display("FAIL beq_not_taken_pc got %h want %h", imemaddr, 32'h104); end
    vectors++; if (redirect !== 1'b0) begin miscompares++; $display("FAIL beq_not_taken_redirect got %b want 0", redirect); end
    // BNE taken with zero=0, +2 words: 0x108 + 8 = 0x110
    zero_sel = 1'b0; zero = 1'b0; imm16 = 16'h0002;
    tick();
    vectors++; if (imemaddr !== 32'h110) begin miscompares++; $display("FAIL bne_taken_pc got %h want %h", imemaddr, 32'h110); end
    vectors++; if (redirect !== 1'b1) begin miscompares++; $display("FAIL bne_taken_redirect got %b want 1", redirect); end
    // BNE not taken with zero=1
    zero = 1'b1;
    tick();
    vectors++; if (imemaddr !== 32'h114) begin miscompares++; $display("FAIL bne_not_taken_pc got %h want %h", imemaddr, 32'h114); end
    vectors++; if (icount !== 32'd5) begin miscompares++; $display("FAIL br_icount got %0d want 5", icount); end
    ihit = 1'b0;
  endtask

  task automatic test_pend();
    do_reset();
    pcsrc = 2'd2; rdat1 = 32'h0040_0000; ihit = 1'b1;
    tick();
    vectors++; if (imemaddr !== 32'h0040_0000) begin miscompares++; $display("FAIL pend_setup_pc got %h want %h", imemaddr, 32'h0040_0000); end
    pcsrc = 2'd1; jaddr = 26'h0000010; ihit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++; if (imemaddr !== 32'h0040_0000) begin miscompares++; $display("FAIL pend_hold_pc[%0d] got %h want %h", i, imemaddr, 32'h0040_0000); end
      vectors++; if (redirect !== 1'b0) begin miscompares++; $display("FAIL pend_hold_redirect[%0d] got %b want 0", i, redirect); end
      vectors++; if (imemREN !== 1'b1) begin miscompares++; $display("FAIL pend_imemREN[%0d] got %b want 1", i, imemREN); end
    end
    // Stall in PEND must also hold everything.
    pcsrc = 2'd0; ihit = 1'b1; stall = 1'b1;
    tick();
    vectors++; if (imemaddr !== 32'h0040_0000) begin miscompares++; $display("FAIL pend_stall_pc got %h want %h", imemaddr, 32'h0040_0000); end
    stall = 1'b0;
    tick();
    vectors++; if (imemaddr !== 32'h0000_0040) begin miscompares++; $display("FAIL pend_release_pc got %h want %h", imemaddr, 32'h0000_0040); end
    vectors++; if (redirect !== 1'b1) begin miscompares++; $display("FAIL pend_release_redirect got %b want 1", redirect); end
    vectors++; if (icount !== 32'd2) begin miscompares++; $display("FAIL pend_icount got %0d want 2", icount); end
    tick();
    vectors++; if (imemaddr !== 32'h0000_0044) begin miscompares++; $display("FAIL pend_after_pc got %h want %h", imemaddr, 32'h0000_0044); end
    vectors++; if (redirect !== 1'b0) begin miscompares++; $display("FAIL pend_single_pulse got %b want 0", redirect); end
    ihit = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    pcsrc = 2'd2; rdat1 = 32'h200; ihit = 1'b1; stall = 1'b1;
    tick();
    vectors++; if (imemaddr !== 32'h0) begin miscompares++; $display("FAIL stall_pc got %h want %h", imemaddr, 32'h0); end
    vectors++; if (icount !== 32'd0) begin miscompares++; $display("FAIL stall_icount got %0d want 0", icount); end
    stall = 1'b0;
    tick();
    vectors++; if (imemaddr !== 32'h200) begin miscompares++; $display("FAIL jr_pc got %h want %h", imemaddr, 32'h200); end
    vectors++; if (redirect !== 1'b1) begin miscompares++; $display("FAIL jr_redirect got %b want 1", redirect); end
    ihit = 1'b0;
  endtask

  task automatic test_halt();
    do_reset();
    pcsrc = 2'd0; ihit = 1'b1;
    tick();
    halt = 1'b1; pcsrc = 2'd1; jaddr = 26'h0000100;
    tick();
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL halt_halted got %b want 1", halted); end
    vectors++; if (imemREN !== 1'b0) begin miscompares++; $display("FAIL halt_imemREN got %b want 0", imemREN); end
    vectors++; if (redirect !== 1'b0) begin miscompares++; $display("FAIL halt_redirect got %b want 0", redirect); end
    halt = 1'b0; pcsrc = 2'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++; if (imemaddr !== 32'h4 || icount !== 32'd1 || halted !== 1'b1) begin miscompares++; $display("FAIL halt_frozen[%0d] got pc=%h cnt=%0d halted=%b want pc=4 cnt=1 halted=1", i, imemaddr, icount, halted); end
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    vectors++; if (imemaddr !== 32'h0 || halted !== 1'b0 || imemREN !== 1'b1 || icount !== 32'd0) begin miscompares++; $display("FAIL halt_reset got pc=%h halted=%b ren=%b cnt=%0d want pc=0 halted=0 ren=1 cnt=0", imemaddr, halted, imemREN, icount); end
    ihit = 1'b0;
  endtask

  task automatic test_reset_in_pend();
    do_reset();
    pcsrc = 2'd1; jaddr = 26'h0000200; ihit = 1'b0;
    tick();
    pcsrc = 2'd0; RST = 1'b1; ihit = 1'b1;
    tick();
    RST = 1'b0;
    vectors++; if (imemaddr !== 32'h0) begin miscompares++; $display("FAIL pend_rst_pc got %h want %h", imemaddr, 32'h0); end
    tick();
    vectors++; if (imemaddr !== 32'h4 || redirect !== 1'b0) begin miscompares++; $display("FAIL pend_rst_resume got pc=%h redir=%b want pc=4 redir=0", imemaddr, redirect); end
    ihit = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    pcsrc = 2'd2; rdat1 = 32'hFFFF_FFFC; ihit = 1'b1;
    tick();
    vectors++; if (pc_plus4 !== 32'h0) begin miscompares++; $display("FAIL wrap_pc_plus4 got %h want %h", pc_plus4, 32'h0); end
    pcsrc = 2'd0;
    tick();
    vectors++; if (imemaddr !== 32'h0) begin miscompares++; $display("FAIL wrap_pc got %h want %h", imemaddr, 32'h0); end
    vectors++; if (icount !== 32'd2) begin miscompares++; $display("FAIL wrap_icount got %0d want 2", icount); end
    ihit = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    RST = 1'b1;
    idle_inputs();
    test_reset();
    test_add4();
    test_branch();
    test_pend();
    test_stall();
    test_halt();
    test_reset_in_pend();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_INIT, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Single clock CLK; reset RST is synchronous, active-high, sampled on CLK rising edge.
REQ-003 CLK  in  1  system clock, all state updates on rising edge.
REQ-004 RST  in  1  synchronous active-high reset.
REQ-005 pcsrc  in  2  next-PC select: 0 ADD4, 1 JUMP, 2 JR, 3 BRANCH.
REQ-006 zero_sel  in  1  branch polarity: 0 BNE, 1 BEQ.
REQ-007 zero  in  1  ALU zero flag for the current instruction.
REQ-008 jaddr  in  26  J-type target field.
REQ-009 imm16  in  16  branch offset field, word units, signed.
REQ-010 rdat1  in  32  JR target register value.
REQ-011 ihit  in  1  instruction memory returned the word at imemaddr this cycle.
REQ-012 stall  in  1  hazard hold; blocks PC update.
REQ-013 halt  in  1  current instruction is HALT.
REQ-014 imemaddr  out  32  current PC.
REQ-015 imemREN  out  1  instruction fetch request.
REQ-016 pc_plus4  out  32  imemaddr+4, combinational, for R31 link write.
REQ-017 redirect  out  1  one-cycle pulse: PC loaded with non-sequential target.
REQ-018 halted  out  1  sequencer in HALT state.
REQ-019 icount  out  32  retired-fetch counter.

Function
REQ-020 States: FETCH, PEND (redirect latched, awaiting ihit), HALT.
REQ-021 advance = ihit & ~stall & (state != HALT).
REQ-022 taken = (pcsrc==BRANCH) & (zero == zero_sel).
REQ-023 Target: ADD4 -> pc+4; JUMP -> {pc_plus4[31:28], jaddr, 2'b00}; JR -> rdat1; BRANCH taken -> pc+4 + (sign-extended imm16 << 2); BRANCH not taken -> pc+4.
REQ-024 All address arithmetic modulo 2^32; overflow wraps silently.
REQ-025 is_redir = (pcsrc==JUMP) | (pcsrc==JR) | taken.
REQ-026 FETCH, advance: PC <= target; icount += 1; redirect = 1 next cycle iff is_redir.
REQ-027 FETCH, is_redir & ~ihit & ~stall: latch target into pend_pc, go to PEND; PC unchanged.
REQ-028 PEND, advance: PC <= pend_pc (current pcsrc ignored), icount += 1, redirect pulses next cycle, return to FETCH.
REQ-029 PEND, ~advance: hold pend_pc and PC.
REQ-030 stall=1: PC, pend_pc, state held; stall overrides ihit.
REQ-031 halt & ihit & ~stall in FETCH or PEND: go to HALT, PC not updated, icount not incremented; halt wins over any simultaneous redirect.
REQ-032 HALT: imemREN=0, halted=1, PC and icount frozen; leave only by RST.
REQ-033 imemREN=1 in FETCH and PEND.
REQ-034 redirect is high for exactly one cycle per redirect, never two consecutive cycles from one redirect.
REQ-035 icount wraps 32'hFFFF_FFFF -> 0.

Reset
REQ-036 RST=1 at any cycle, including PEND or HALT: next cycle PC=PC_INIT, state=FETCH, pend_pc=0, icount=0, redirect=0, halted=0, imemREN=1.
REQ-037 RST has priority over every other input.

Verification
REQ-038 Reset, pcsrc=ADD4, ihit=1 for 3 cycles -> imemaddr 0,4,8,C; icount=3; redirect never set.
REQ-039 PC=0x100, pcsrc=BRANCH, zero_sel=BEQ, zero=1, imm16=16'hFFFF, ihit=1 -> PC=0x100; redirect pulse; repeat with zero=0 -> PC=0x104, no pulse.
REQ-040 PC=0x0040_0000, pcsrc=JUMP, jaddr=26'h0000010, ihit=0 two cycles, then pcsrc=ADD4, ihit=1 -> PEND held, then PC=0x0000_0040, redirect pulse.
REQ-041 pcsrc=JR, rdat1=0x200, ihit=1, stall=1 -> PC unchanged; stall=0 -> PC=0x200.
REQ-042 halt=1, pcsrc=JUMP, ihit=1 -> halted=1, imemREN=0, PC and icount frozen for 10 cycles; RST -> PC=PC_INIT, halted=0.
REQ-043 PC=0xFFFF_FFFC, pcsrc=ADD4, ihit=1 -> PC=0x0000_0000.
